lm_sm_sequencer: RTL
====================

// Module: lm_sm_sequencer
// PURPOSE
//  Sequences the register file and data memory for load-multiple (LM) and store-multiple (SM).
//  Walks an 8-bit register mask from the lowest set bit upward, one transfer per accepted memory access.
//  Memory addresses run consecutively from a base address.
//  Sits between the decode/execute control and the register file's single write port and read port.
//  Owns those ports while busy.
// PARAMETERS
//  REG_FILE_WIDTH  8   number of architectural registers; equals the mask width
//  RADDR_W         3   register address width, clog2(REG_FILE_WIDTH)
//  DATA_W          16  register/memory data and address width
// PORTS
//  clk            in   1        clock, rising edge
//  resetn         in   1        asynchronous active-low reset
//  start          in   1        begin an LM/SM; sampled only in IDLE
//  is_load        in   1        1 = LM (mem->reg), 0 = SM (reg->mem); latched on start
//  reg_mask       in   8        bit i set => register i is transferred; latched on start
//  base_addr      in   DATA_W   first memory address; latched on start
//  busy           out  1        high in ACCESS and DONE states
//  done           out  1        one-cycle completion pulse
//  mem_addr       out  DATA_W   current memory address
//  mem_rd         out  1        memory read request (LM)
//  mem_wr         out  1        memory write request (SM)
//  mem_wdata      out  DATA_W   store data (equals rf_read_data)
//  mem_rdata      in   DATA_W   load data; valid in the cycle mem_ready=1
//  mem_ready      in   1        memory completes the current request this cycle
//  rf_read_addr   out  RADDR_W  register being stored (SM)
//  rf_read_data   in   DATA_W   register file read data for rf_read_addr (combinational)
//  rf_write_addr  out  RADDR_W  register being loaded (LM)
//  rf_write_data  out  DATA_W   equals mem_rdata
//  rf_write_en    out  1        register file write strobe
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; remaining mask, address pointer and latched op cleared.
//   All outputs 0. No rf_write_en or mem request may assert in the reset cycle.
//  States: IDLE -> ACCESS -> DONE -> IDLE.
//  IDLE: start=1 latches reg_mask, base_addr and is_load into rem_mask, addr_ptr and op.
//   Next state is ACCESS, or DONE if reg_mask==0; a zero mask performs no access and still pulses done.
//  ACCESS:
//   cur = index of the lowest set bit of rem_mask (priority to register 0).
//   Outputs: mem_addr=addr_ptr; mem_rd=op; mem_wr=~op; rf_read_addr=cur; rf_write_addr=cur.
//   Request stays asserted, stable, until mem_ready=1.
//   On mem_ready=1:
//    - LM: rf_write_en=1 in the same cycle, rf_write_data=mem_rdata.
//    - Clear rem_mask[cur]; addr_ptr <= addr_ptr+1, modulo 2^DATA_W (0xFFFF wraps to 0x0000).
//    - If the cleared rem_mask is 0, next state is DONE.
//   mem_ready=0: hold all state; rf_write_en=0.
//  Address stepping: addr_ptr advances once per transferred register; unset mask bits consume no address.
//  DONE: done=1, busy=1, no memory request; next state IDLE.
//  busy=0 only in IDLE. start while busy is ignored (not queued).
//  start in the same cycle done is high is ignored; start may be accepted the following cycle.
//  rf_write_en and mem_wr are never high together.
//  mem_rd/mem_wr are never high outside ACCESS.
//  Latency: with mem_ready held 1 and N set bits:
//   start sampled at edge 0; accesses occupy cycles 1..N; done in cycle N+1; idle in cycle N+2.
//  Reset mid-operation: abandon the transfer immediately.
//   Registers already written stay written; no done pulse.
// TESTING
//  1. LM, mask=0x81, base=0x0100, ready=1:
//     -> writes R0 <= mem[0x0100] then R7 <= mem[0x0101]; done in cycle 3.
//  2. SM, mask=0xFF, base=0x0020:
//     -> mem_wr on addrs 0x20..0x27 with wdata=R0..R7 in order; exactly 8 writes; no rf_write_en.
//  3. mask=0x00 start -> no mem_rd/mem_wr, done pulses in cycle 1, busy high 1 cycle only.
//  4. LM mask=0x06, mem_ready low for 3 cycles on the first access:
//     -> addr 0x0100 and mem_rd held stable.
//     -> R1 is written only on the ready cycle; R2 at 0x0101 follows.
//  5. SM mask=0x03, base=0xFFFF -> addresses 0xFFFF then 0x0000 (wrap); done after 2 accesses.
//  6. Reset asserted mid-LM (after 1 of 3 writes), start pulsed again while busy before that:
//     -> the extra start is ignored.
//     -> after reset: outputs 0, state IDLE, no done; a new start is accepted normally.

Source files
------------

// File: rtl/lm_sm_sequencer.sv
// Load-multiple / store-multiple sequencer: walks a register mask from bit 0 upward,
// issuing one memory access per set bit at consecutive addresses from a latched base.
module lm_sm_sequencer #(
    parameter int REG_FILE_WIDTH = 8,
    parameter int RADDR_W        = 3,
    parameter int DATA_W         = 16
) (
    input  logic                      clk_i,
    input  logic                      resetn_i,
    input  logic                      start_i,
    input  logic                      is_load_i,
    input  logic [REG_FILE_WIDTH-1:0] reg_mask_i,
    input  logic [DATA_W-1:0]         base_addr_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [DATA_W-1:0]         mem_addr_o,
    output logic                      mem_rd_o,
    output logic                      mem_wr_o,
    output logic [DATA_W-1:0]         mem_wdata_o,
    input  logic [DATA_W-1:0]         mem_rdata_i,
    input  logic                      mem_ready_i,
    output logic [RADDR_W-1:0]        rf_read_addr_o,
    input  logic [DATA_W-1:0]         rf_read_data_i,
    output logic [RADDR_W-1:0]        rf_write_addr_o,
    output logic [DATA_W-1:0]         rf_write_data_o,
    output logic                      rf_write_en_o
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                    state_q;
    logic [REG_FILE_WIDTH-1:0] rem_q;
    logic [DATA_W-1:0]         addr_q;
    logic                      op_q;
    logic [RADDR_W-1:0]        cur_q;
    logic [REG_FILE_WIDTH-1:0] rem_d;

    function automatic logic [RADDR_W-1:0] lowest(input logic [REG_FILE_WIDTH-1:0] m);
        logic [RADDR_W-1:0] idx;
        idx = '0;
        for (int i = REG_FILE_WIDTH - 1; i >= 0; i--)
            if (m[i]) idx = RADDR_W'(i);
        return idx;
    endfunction

    // cur_q always tracks the lowest set bit of rem_q, so clearing it is a single mask op
    assign rem_d = rem_q & ~(REG_FILE_WIDTH'(1) << cur_q);

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= IDLE;
            rem_q   <= '0;
            addr_q  <= '0;
            op_q    <= 1'b0;
            cur_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (start_i) begin
                    rem_q   <= reg_mask_i;
                    addr_q  <= base_addr_i;
                    op_q    <= is_load_i;
                    cur_q   <= lowest(reg_mask_i);
                    state_q <= (reg_mask_i == '0) ? DONE : ACCESS;
                end
                ACCESS: if (mem_ready_i) begin
                    rem_q  <= rem_d;
                    addr_q <= addr_q + 1'b1;
                    cur_q  <= lowest(rem_d);
                    if (rem_d == '0) state_q <= DONE;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs decode straight from registers; only the write strobe and data paths see inputs
    assign busy_o          = (state_q != IDLE);
    assign done_o          = (state_q == DONE);
    assign mem_rd_o        = (state_q == ACCESS) &&  op_q;
    assign mem_wr_o        = (state_q == ACCESS) && !op_q;
    assign mem_addr_o      = addr_q;
    assign rf_read_addr_o  = cur_q;
    assign rf_write_addr_o = cur_q;
    assign mem_wdata_o     = mem_wr_o ? rf_read_data_i : '0;
    assign rf_write_data_o = mem_rd_o ? mem_rdata_i : '0;
    assign rf_write_en_o   = mem_rd_o && mem_ready_i;

endmodule
